mux_rr_arbiter: RTL and testbench

- Upstream control stage for the parametric multiplexer.
- Arbitrates 2**N_SEL requesting channels round-robin and drives the mux selector.
- Captures the selected W_DW-bit word into an output register with valid/ready handshake toward the downstream consumer.
- Sits between the per-channel data producers and the selected-data consumer; owns fairness and backpressure.

---
 rtl/mux_pkg.sv | 27 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 45 ++++
 rtl/mux_sel.sv | 18 +
 rtl/mux_rr_arbiter.sv | 90 +++++++++
 tb/tb_mux_rr_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared widths, types and states for the multiplexer slice
//
// Purpose: common constants and types used by the mux, the round-robin
//          picker and the arbiter top.
// Contents:
//    W_DW        data width of one channel word
//    N_SEL       selector width
//    N_CH        number of channels (2**N_SEL)
//    dtwidth_t   one channel word
//    selectr_t   channel index / mux selector
//    in_bus_t    packed channel data, channel k in slice k
//    req_vec_t   one bit per channel (requests, grants)
//    arb_state_e output register occupancy
package mux_pkg;

   localparam int W_DW  = 6;
   localparam int N_SEL = 2;
   localparam int N_CH  = 2 ** N_SEL;

   typedef logic [W_DW-1:0]      dtwidth_t;
   typedef logic [N_SEL-1:0]     selectr_t;
   typedef logic [N_CH*W_DW-1:0] in_bus_t;
   typedef logic [N_CH-1:0]      req_vec_t;

   typedef enum logic {EMPTY, FULL} arb_state_e;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rtl/mux_rr_arbiter_rr_pick.sv - combinational round-robin winner search
//
// Purpose: finds the first set request at or after ptr+1, wrapping around.
// Ports:
//    req     in   per-channel request vector
//    ptr     in   last granted channel
//    found   out  at least one request is set
//    winner  out  index of the winning channel
//    onehot  out  one-hot form of winner (zero when nothing found)
module rr_pick
   import mux_pkg::*;
(
   input  req_vec_t req,
   input  selectr_t ptr,
   output logic     found,
   output selectr_t winner,
   output req_vec_t onehot
);

   selectr_t base;
   selectr_t off;
   req_vec_t rot;

   // Rotate so that bit 0 of rot is channel ptr+1, priority-encode the
   // lowest set bit, then add the base back. The index arithmetic is
   // N_SEL bits wide, so the modulo wrap comes for free.
   always_comb begin
      base   = ptr + 1'b1;
      rot    = '0;
      off    = '0;
      found  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         rot[i] = req[selectr_t'(base + selectr_t'(i))];
      end
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = selectr_t'(i);
         end
      end
      winner = base + off;
      onehot = found ? (req_vec_t'(1) << winner) : '0;
   end

endmodule

// File: rtl/mux_sel.sv
// rtl/mux_sel.sv - N_CH-to-1 word multiplexer
//
// Purpose: selects one W_DW-bit channel word from the packed channel bus.
// Ports:
//    data  in   packed channel words, channel k in slice k
//    sel   in   index of the channel to pass through
//    word  out  selected channel word
module mux_sel
   import mux_pkg::*;
(
   input  in_bus_t  data,
   input  selectr_t sel,
   output dtwidth_t word
);

   assign word = data[sel*W_DW +: W_DW];

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin channel arbiter with registered output
//
// Purpose: grants one of N_CH requesters round-robin, steers the mux to it
//          and captures the selected word in a valid/ready output register.
// Ports:
//    clk     in   clock
//    rst     in   asynchronous active-high reset
//    req_i   in   per-channel request
//    data_i  in   packed channel data
//    gnt_o   out  one-hot grant (transfer when req_i[k] & gnt_o[k])
//    sel_o   out  mux selector / granted channel index
//    vld_o   out  output register holds a word
//    data_o  out  registered selected word
//    rdy_i   in   downstream ready (transfer when vld_o & rdy_i)
module mux_rr_arbiter
   import mux_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  req_vec_t req_i,
   input  in_bus_t  data_i,
   output req_vec_t gnt_o,
   output selectr_t sel_o,
   output logic     vld_o,
   output dtwidth_t data_o,
   input  logic     rdy_i
);

   arb_state_e state;
   selectr_t   ptr;
   logic       found;
   selectr_t   winner;
   req_vec_t   onehot;
   dtwidth_t   mux_word;
   logic       accept;
   logic       grant;

   rr_pick u_pick (
      .req    (req_i),
      .ptr    (ptr),
      .found  (found),
      .winner (winner),
      .onehot (onehot)
   );

   mux_sel u_mux (
      .data (data_i),
      .sel  (sel_o),
      .word (mux_word)
   );

   assign vld_o  = (state == FULL);
   // The register can load when empty or when its word leaves this cycle.
   assign accept = !vld_o || rdy_i;
   // Gated by rst so no handshake completes while reset is asserted.
   assign grant  = accept && found && !rst;
   assign gnt_o  = grant ? onehot : '0;
   // With no requests the selector rests on the last granted channel.
   assign sel_o  = rst ? '0 : (found ? winner : ptr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= EMPTY;
         data_o <= '0;
         ptr    <= selectr_t'(N_CH - 1);
      end else begin
         case (state)
            EMPTY: begin
               if (grant) begin
                  data_o <= mux_word;
                  ptr    <= winner;
                  state  <= FULL;
               end
            end
            FULL: begin
               // A new load takes priority over a plain drain.
               if (grant) begin
                  data_o <= mux_word;
                  ptr    <= winner;
                  state  <= FULL;
               end else if (rdy_i) begin
                  state  <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
   import mux_pkg::*;

   logic     clk;
   logic     rst;
   req_vec_t req_i;
   in_bus_t  data_i;
   req_vec_t gnt_o;
   selectr_t sel_o;
   logic     vld_o;
   dtwidth_t data_o;
   logic     rdy_i;

   int pass_cnt;
   int tot_cnt;

   typedef struct packed {
      req_vec_t gnt;
      selectr_t sel;
   } gnt_exp_t;

   gnt_exp_t exp_gnt[$];
   dtwidth_t exp_data[$];

   mux_rr_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .req_i  (req_i),
      .data_i (data_i),
      .gnt_o  (gnt_o),
      .sel_o  (sel_o),
      .vld_o  (vld_o),
      .data_o (data_o),
      .rdy_i  (rdy_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic in_bus_t bus(input dtwidth_t c3, input dtwidth_t c2,
                                   input dtwidth_t c1, input dtwidth_t c0);
      return {c3, c2, c1, c0};
   endfunction

   task automatic drive(input req_vec_t r, input in_bus_t d, input logic y);
      req_i  = r;
      data_i = d;
      rdy_i  = y;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_gnt(input req_vec_t g, input selectr_t s);
      gnt_exp_t e;
      e.gnt = g;
      e.sel = s;
      exp_gnt.push_back(e);
   endtask

   // Monitor: compares grants and output transfers as the DUT presents them.
   always @(negedge clk) begin
      if (!rst) begin
         if (gnt_o != '0) begin
            if (exp_gnt.size() == 0) begin
               check("gnt_unexpected", 32'(gnt_o), 32'h0);
            end else begin
               gnt_exp_t e;
               e = exp_gnt.pop_front();
               check("gnt", 32'(gnt_o), 32'(e.gnt));
               check("sel", 32'(sel_o), 32'(e.sel));
            end
         end
         if (vld_o && rdy_i) begin
            if (exp_data.size() == 0) begin
               check("data_unexpected", 32'(data_o), 32'hFFFF);
            end else begin
               dtwidth_t d;
               d = exp_data.pop_front();
               check("data_out", 32'(data_o), 32'(d));
            end
         end
      end
   end

   initial begin
      pass_cnt = 0;
      tot_cnt  = 0;
      rst      = 1'b1;
      drive(4'b1111, bus(6'h04, 6'h03, 6'h02, 6'h01), 1'b1);

      // Reset state
      #2;
      check("rst_vld", 32'(vld_o), 32'h0);
      check("rst_data", 32'(data_o), 32'h0);
      check("rst_gnt", 32'(gnt_o), 32'h0);
      check("rst_sel", 32'(sel_o), 32'h0);
      tick();
      tick();
      rst = 1'b0;

      // Round-robin with all channels requesting
      for (int k = 0; k < 8; k++) begin
         push_gnt(req_vec_t'(1) << (k % 4), selectr_t'(k % 4));
         exp_data.push_back(dtwidth_t'((k % 4) + 1));
         tick();
      end

      // Single grant on channel 2 to park ptr at 2
      drive(4'b0100, bus(6'h00, 6'h22, 6'h00, 6'h00), 1'b1);
      push_gnt(4'b0100, 2'd2);
      exp_data.push_back(6'h22);
      tick();

      // Sparse requests with wrap: 0, 1, 0
      drive(4'b0011, bus(6'h00, 6'h00, 6'h11, 6'h10), 1'b1);
      push_gnt(4'b0001, 2'd0); exp_data.push_back(6'h10);
      push_gnt(4'b0010, 2'd1); exp_data.push_back(6'h11);
      push_gnt(4'b0001, 2'd0); exp_data.push_back(6'h10);
      tick();
      tick();
      tick();

      // Load 0x15 from channel 1, then backpressure
      drive(4'b0010, bus(6'h00, 6'h00, 6'h15, 6'h00), 1'b1);
      push_gnt(4'b0010, 2'd1);
      exp_data.push_back(6'h15);
      tick();
      drive(4'b0100, bus(6'h00, 6'h2C, 6'h00, 6'h00), 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_gnt", 32'(gnt_o), 32'h0);
         check("stall_data", 32'(data_o), 32'h15);
         check("stall_vld", 32'(vld_o), 32'h1);
         tick();
      end
      rdy_i = 1'b1;
      push_gnt(4'b0100, 2'd2);
      exp_data.push_back(6'h2C);
      tick();

      // Drain to empty after one transfer from channel 3
      drive(4'b1000, bus(6'h33, 6'h00, 6'h00, 6'h00), 1'b1);
      push_gnt(4'b1000, 2'd3);
      exp_data.push_back(6'h33);
      tick();
      drive(4'b0000, bus(6'h33, 6'h00, 6'h00, 6'h00), 1'b1);
      @(negedge clk);
      check("drain_vld_one", 32'(vld_o), 32'h1);
      tick();
      @(negedge clk);
      check("drain_vld", 32'(vld_o), 32'h0);
      check("drain_data_held", 32'(data_o), 32'h33);
      check("drain_sel_ptr", 32'(sel_o), 32'h3);
      tick();

      // Single persistent requester on channel 1
      drive(4'b0010, bus(6'h00, 6'h00, 6'h09, 6'h00), 1'b1);
      for (int k = 0; k < 4; k++) begin
         push_gnt(4'b0010, 2'd1);
         exp_data.push_back(6'h09);
      end
      for (int k = 0; k < 4; k++) tick();
      drive(4'b0000, bus(6'h00, 6'h00, 6'h09, 6'h00), 1'b1);
      tick();

      // Reset mid-operation with a pending word
      drive(4'b0001, bus(6'h00, 6'h00, 6'h00, 6'h2A), 1'b0);
      push_gnt(4'b0001, 2'd0);
      tick();
      drive(4'b0000, bus(6'h00, 6'h00, 6'h00, 6'h2A), 1'b0);
      @(negedge clk);
      check("pre_rst_vld", 32'(vld_o), 32'h1);
      check("pre_rst_data", 32'(data_o), 32'h2A);
      #2;
      rst = 1'b1;
      drive(4'b1111, bus(6'h04, 6'h03, 6'h02, 6'h01), 1'b1);
      #1;
      check("async_rst_vld", 32'(vld_o), 32'h0);
      check("async_rst_data", 32'(data_o), 32'h0);
      check("async_rst_gnt", 32'(gnt_o), 32'h0);
      check("async_rst_sel", 32'(sel_o), 32'h0);
      tick();
      rst = 1'b0;
      push_gnt(4'b0001, 2'd0);
      exp_data.push_back(6'h01);
      tick();
      drive(4'b0000, bus(6'h04, 6'h03, 6'h02, 6'h01), 1'b1);
      tick();
      tick();

      check("gnt_queue_empty", 32'(exp_gnt.size()), 32'h0);
      check("data_queue_empty", 32'(exp_data.size()), 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
